target_lock_ctrl: RTL

- Sequential lock-on controller sitting directly upstream of the overlay pixel mixer.
- Turns mouse clicks into a lock on one of N_TARGETS detected objects by hit-testing the click against the per-target bounding boxes.
- Tracks that target across frames and tolerates short detection dropouts.
- Drives the mixer's is_locked, locked_idx and center_hit inputs.

---
 rtl/target_lock_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/target_lock_ctrl.sv
// Lock-on controller feeding the overlay pixel mixer.
// A left click starts a one-slot-per-cycle hit test of the cursor against the
// per-target bounding boxes. The lowest-index hit becomes the locked target.
// That target is then tracked across frames, and short detection dropouts are
// tolerated. A right click always releases the lock.
module target_lock_ctrl #(
    parameter int N_TARGETS   = 16,
    parameter int LOST_FRAMES = 30,
    parameter int CX_MIN      = 288,
    parameter int CX_MAX      = 351,
    parameter int CY_MIN      = 208,
    parameter int CY_MAX      = 271,
    localparam int IDX_W      = $clog2(N_TARGETS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         click_l,
    input  logic                         click_r,
    input  logic [9:0]                   mouse_x_pixel,
    input  logic [9:0]                   mouse_y_pixel,
    input  logic [N_TARGETS-1:0][9:0]    aim_x_all,
    input  logic [N_TARGETS-1:0][9:0]    aim_y_all,
    input  logic [N_TARGETS-1:0]         aim_detected_all,
    input  logic [N_TARGETS-1:0][11:0]   box_x_min_all,
    input  logic [N_TARGETS-1:0][11:0]   box_x_max_all,
    input  logic [N_TARGETS-1:0][11:0]   box_y_min_all,
    input  logic [N_TARGETS-1:0][11:0]   box_y_max_all,
    output logic                         is_locked,
    output logic [IDX_W-1:0]             locked_idx,
    output logic                         center_hit,
    output logic [1:0]                   lock_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    localparam logic [9:0]       CX_MIN_V  = 10'(CX_MIN);
    localparam logic [9:0]       CX_MAX_V  = 10'(CX_MAX);
    localparam logic [9:0]       CY_MIN_V  = 10'(CY_MIN);
    localparam logic [9:0]       CY_MAX_V  = 10'(CY_MAX);
    localparam logic [7:0]       LOST_LIM  = 8'(LOST_FRAMES);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_TARGETS - 1);

    // Inclusive unsigned range test on 12-bit box coordinates.
    function automatic logic in_range12(input logic [11:0] v,
                                        input logic [11:0] lo,
                                        input logic [11:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Inclusive unsigned range test on 10-bit pixel coordinates.
    function automatic logic in_range10(input logic [9:0] v,
                                        input logic [9:0] lo,
                                        input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    state_t             state_r, state_s;
    state_t             ret_r, ret_s;
    logic               prev_l_r, prev_r_r;
    logic [9:0]         mx_r, mx_s, my_r, my_s;
    logic [IDX_W-1:0]   scan_r, scan_s;
    logic [IDX_W-1:0]   cand_r, cand_s;
    logic               found_r, found_s;
    logic [7:0]         lost_cnt_r, lost_cnt_s;
    logic [IDX_W-1:0]   locked_idx_r, locked_idx_s;
    logic               is_locked_r, is_locked_s;
    logic               center_hit_r, center_hit_s;

    logic               rise_r_s, rise_l_s;
    logic               hit_s, lock_det_s, win_s;
    logic [7:0]         lost_inc_s, lost_sat_s, cnt_tick_s;

    // Right wins over a simultaneous left rise, so left is masked by it.
    assign rise_r_s   = click_r & ~prev_r_r;
    assign rise_l_s   = click_l & ~prev_l_r & ~rise_r_s;

    // Hit test of the latched cursor against the slot under scan.
    assign hit_s = aim_detected_all[scan_r]
                 & in_range12({2'b00, mx_r}, box_x_min_all[scan_r], box_x_max_all[scan_r])
                 & in_range12({2'b00, my_r}, box_y_min_all[scan_r], box_y_max_all[scan_r]);

    assign lock_det_s = aim_detected_all[locked_idx_r];
    assign win_s      = lock_det_s
                      & in_range10(aim_x_all[locked_idx_r], CX_MIN_V, CX_MAX_V)
                      & in_range10(aim_y_all[locked_idx_r], CY_MIN_V, CY_MAX_V);

    assign lost_inc_s = lost_cnt_r + 8'd1;
    assign lost_sat_s = (lost_cnt_r >= LOST_LIM) ? lost_cnt_r : lost_inc_s;

    // Dropout count seen by a search launched from LOST: missed ticks keep counting.
    always_comb begin
        cnt_tick_s = lost_cnt_r;
        if ((ret_r == ST_LOST) && frame_tick && !lock_det_s) begin
            cnt_tick_s = lost_sat_s;
        end else begin
            cnt_tick_s = lost_cnt_r;
        end
    end

    // Next-state and next-output logic; priority is right > completion > tick > left.
    always_comb begin
        state_s      = state_r;
        ret_s        = ret_r;
        mx_s         = mx_r;
        my_s         = my_r;
        scan_s       = scan_r;
        cand_s       = cand_r;
        found_s      = found_r;
        lost_cnt_s   = lost_cnt_r;
        locked_idx_s = locked_idx_r;
        is_locked_s  = is_locked_r;
        center_hit_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rise_l_s) begin
                    state_s = ST_SEARCH;
                    ret_s   = ST_IDLE;
                    mx_s    = mouse_x_pixel;
                    my_s    = mouse_y_pixel;
                    scan_s  = '0;
                    cand_s  = '0;
                    found_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SEARCH: begin
                if (rise_r_s) begin
                    state_s      = ST_IDLE;
                    locked_idx_s = '0;
                    lost_cnt_s   = 8'd0;
                end else if (scan_r == LAST_SLOT) begin
                    if (found_r || hit_s) begin
                        state_s      = ST_LOCKED;
                        locked_idx_s = found_r ? cand_r : scan_r;
                        lost_cnt_s   = 8'd0;
                    end else if ((ret_r == ST_LOST) && (cnt_tick_s >= LOST_LIM)) begin
                        state_s      = ST_IDLE;
                        locked_idx_s = '0;
                        lost_cnt_s   = 8'd0;
                    end else begin
                        state_s    = ret_r;
                        lost_cnt_s = cnt_tick_s;
                    end
                end else begin
                    scan_s     = scan_r + IDX_W'(1);
                    lost_cnt_s = cnt_tick_s;
                    if (hit_s && !found_r) begin
                        found_s = 1'b1;
                        cand_s  = scan_r;
                    end else begin
                        found_s = found_r;
                    end
                end
            end

            ST_LOCKED: begin
                if (rise_r_s) begin
                    state_s      = ST_IDLE;
                    locked_idx_s = '0;
                end else if (frame_tick && !lock_det_s) begin
                    if (LOST_LIM == 8'd1) begin
                        state_s      = ST_IDLE;
                        locked_idx_s = '0;
                        lost_cnt_s   = 8'd0;
                    end else begin
                        state_s    = ST_LOST;
                        lost_cnt_s = 8'd1;
                    end
                end else if (rise_l_s) begin
                    state_s = ST_SEARCH;
                    ret_s   = ST_LOCKED;
                    mx_s    = mouse_x_pixel;
                    my_s    = mouse_y_pixel;
                    scan_s  = '0;
                    cand_s  = '0;
                    found_s = 1'b0;
                end else begin
                    state_s = ST_LOCKED;
                end
            end

            ST_LOST: begin
                if (rise_r_s) begin
                    state_s      = ST_IDLE;
                    locked_idx_s = '0;
                    lost_cnt_s   = 8'd0;
                end else if (frame_tick) begin
                    if (lock_det_s) begin
                        state_s    = ST_LOCKED;
                        lost_cnt_s = 8'd0;
                    end else if (lost_inc_s == LOST_LIM) begin
                        state_s      = ST_IDLE;
                        locked_idx_s = '0;
                        lost_cnt_s   = 8'd0;
                    end else begin
                        lost_cnt_s = lost_inc_s;
                    end
                end else if (rise_l_s) begin
                    state_s = ST_SEARCH;
                    ret_s   = ST_LOST;
                    mx_s    = mouse_x_pixel;
                    my_s    = mouse_y_pixel;
                    scan_s  = '0;
                    cand_s  = '0;
                    found_s = 1'b0;
                end else begin
                    state_s = ST_LOST;
                end
            end

            default: begin
                state_s      = ST_IDLE;
                locked_idx_s = '0;
                lost_cnt_s   = 8'd0;
            end
        endcase

        // Lock flag follows the destination state; a search keeps the old value.
        if ((state_s == ST_LOCKED) || (state_s == ST_LOST)) begin
            is_locked_s = 1'b1;
        end else if (state_s == ST_IDLE) begin
            is_locked_s = 1'b0;
        end else begin
            is_locked_s = is_locked_r;
        end

        // Center hit is only reported while the lock stays in LOCKED.
        if ((state_r == ST_LOCKED) && (state_s == ST_LOCKED)) begin
            center_hit_s = win_s;
        end else begin
            center_hit_s = 1'b0;
        end
    end

    // Click edge history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_l_r <= 1'b0;
            prev_r_r <= 1'b0;
        end else begin
            prev_l_r <= click_l;
            prev_r_r <= click_r;
        end
    end

    // Controller state, search context and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ret_r        <= ST_IDLE;
            mx_r         <= 10'd0;
            my_r         <= 10'd0;
            scan_r       <= '0;
            cand_r       <= '0;
            found_r      <= 1'b0;
            lost_cnt_r   <= 8'd0;
            locked_idx_r <= '0;
            is_locked_r  <= 1'b0;
            center_hit_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            ret_r        <= ret_s;
            mx_r         <= mx_s;
            my_r         <= my_s;
            scan_r       <= scan_s;
            cand_r       <= cand_s;
            found_r      <= found_s;
            lost_cnt_r   <= lost_cnt_s;
            locked_idx_r <= locked_idx_s;
            is_locked_r  <= is_locked_s;
            center_hit_r <= center_hit_s;
        end
    end

    assign is_locked  = is_locked_r;
    assign locked_idx = locked_idx_r;
    assign center_hit = center_hit_r;
    assign lock_state = state_r;

endmodule
